// File: rtl/board_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : board_ctrl
//  Description : Tic-tac-toe board stage. Owns the 3x3 board and the turn
//                flag, takes moves from the shared move bus (square index,
//                submit strobe, game reset), validates and records them, and
//                reports win/tie.
//  Ports       : clk, rst           clock, synchronous active-high reset
//                update_loc_i [3:0] square 0..8, row-major, 0 = top-left
//                submit_i           move strobe, rising edge counts
//                reset_i            game reset (level, synchronous)
//                turn_o             0 = player to move, 1 = AI to move
//                board_p_o [8:0]    player marks, bit i = square i
//                board_a_o [8:0]    AI marks, bit i = square i
//                move_count_o [3:0] accepted moves this game (0..9)
//                move_err_o         high ERR_HOLD cycles after a rejection
//                game_over_o        high while the game is finished
//                winner_o [1:0]     00 none, 01 player, 10 AI, 11 tie
//  Revision    : 1.0  initial release
// ============================================================================
module board_ctrl #(
  parameter logic        FIRST_TURN = 1'b0,
  parameter int unsigned ERR_HOLD   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] update_loc_i,
  input  logic       submit_i,
  input  logic       reset_i,
  output logic       turn_o,
  output logic [8:0] board_p_o,
  output logic [8:0] board_a_o,
  output logic [3:0] move_count_o,
  output logic       move_err_o,
  output logic       game_over_o,
  output logic [1:0] winner_o
);

  localparam logic [2:0] c_ERR_HOLD = 3'(ERR_HOLD);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_CHECK = 2'd1,
    S_OVER  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [8:0] board_p_q, board_p_d;
  logic [8:0] board_a_q, board_a_d;
  logic [3:0] count_q, count_d;
  logic       turn_q, turn_d;
  logic [2:0] err_q, err_d;
  logic [1:0] winner_q, winner_d;
  logic       sub_q, sub_d;

  logic       w_sub_rise;
  logic [8:0] w_onehot;
  logic       w_legal;
  logic [8:0] w_plane;

  function automatic logic f_has_line(input logic [8:0] b);
    return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
           (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
           (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
  endfunction

  assign w_sub_rise = submit_i & ~sub_q;
  // Shifting past bit 8 yields zero, so out-of-range squares never alias a real one.
  assign w_onehot   = 9'd1 << update_loc_i;
  assign w_legal    = (update_loc_i <= 4'd8) && (((board_p_q | board_a_q) & w_onehot) == 9'd0);
  // The mover's plane: turn has not toggled yet while in S_CHECK.
  assign w_plane    = turn_q ? board_a_q : board_p_q;

  always_comb begin
    state_d   = state_q;
    board_p_d = board_p_q;
    board_a_d = board_a_q;
    count_d   = count_q;
    turn_d    = turn_q;
    winner_d  = winner_q;
    sub_d     = submit_i;
    err_d     = (err_q != 3'd0) ? err_q - 3'd1 : 3'd0;

    if (reset_i) begin
      state_d   = S_WAIT;
      board_p_d = 9'd0;
      board_a_d = 9'd0;
      count_d   = 4'd0;
      turn_d    = FIRST_TURN;
      winner_d  = 2'b00;
      sub_d     = 1'b0;
      err_d     = 3'd0;
    end else begin
      unique case (state_q)
        S_WAIT: begin
          if (w_sub_rise) begin
            if (w_legal) begin
              if (turn_q) board_a_d = board_a_q | w_onehot;
              else        board_p_d = board_p_q | w_onehot;
              count_d = count_q + 4'd1;
              state_d = S_CHECK;
            end else begin
              err_d = c_ERR_HOLD;
            end
          end
        end
        S_CHECK: begin
          if (f_has_line(w_plane)) begin
            winner_d = turn_q ? 2'b10 : 2'b01;
            state_d  = S_OVER;
          end else if (count_q == 4'd9) begin
            winner_d = 2'b11;
            state_d  = S_OVER;
          end else begin
            turn_d  = ~turn_q;
            state_d = S_WAIT;
          end
        end
        S_OVER: begin
          state_d = S_OVER;
        end
        default: begin
          state_d = S_WAIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_WAIT;
      board_p_q <= 9'd0;
      board_a_q <= 9'd0;
      count_q   <= 4'd0;
      turn_q    <= FIRST_TURN;
      winner_q  <= 2'b00;
      sub_q     <= 1'b0;
      err_q     <= 3'd0;
    end else begin
      state_q   <= state_d;
      board_p_q <= board_p_d;
      board_a_q <= board_a_d;
      count_q   <= count_d;
      turn_q    <= turn_d;
      winner_q  <= winner_d;
      sub_q     <= sub_d;
      err_q     <= err_d;
    end
  end

  assign turn_o       = turn_q;
  assign board_p_o    = board_p_q;
  assign board_a_o    = board_a_q;
  assign move_count_o = count_q;
  assign move_err_o   = (err_q != 3'd0);
  assign game_over_o  = (state_q == S_OVER);
  assign winner_o     = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_board_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_board_ctrl
//  Description : Self-checking bench for board_ctrl (table-driven game plus
//                hand-written multi-cycle sequences).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_board_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] update_loc;
  logic       submit;
  logic       reset;

  logic       turn0, err0, over0;
  logic [8:0] bp0, ba0;
  logic [3:0] cnt0;
  logic [1:0] win0;

  logic       turn1, err1, over1;
  logic [8:0] bp1, ba1;
  logic [3:0] cnt1;
  logic [1:0] win1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  board_ctrl #(.FIRST_TURN(1'b0), .ERR_HOLD(1)) dut (
    .clk(clk), .rst(rst), .update_loc_i(update_loc), .submit_i(submit), .reset_i(reset),
    .turn_o(turn0), .board_p_o(bp0), .board_a_o(ba0), .move_count_o(cnt0),
    .move_err_o(err0), .game_over_o(over0), .winner_o(win0)
  );

  board_ctrl #(.FIRST_TURN(1'b1), .ERR_HOLD(1)) dut_ai (
    .clk(clk), .rst(rst), .update_loc_i(update_loc), .submit_i(submit), .reset_i(reset),
    .turn_o(turn1), .board_p_o(bp1), .board_a_o(ba1), .move_count_o(cnt1),
    .move_err_o(err1), .game_over_o(over1), .winner_o(win1)
  );

  typedef struct {
    logic [3:0] loc;
    logic [8:0] p;
    logic [8:0] a;
    logic       turn;
    logic [3:0] cnt;
    logic       over;
    logic [1:0] win;
  } vec_t;

  vec_t       tie_v [9];
  logic [3:0] ai_win_moves [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Submit edge, then the S_CHECK cycle.
  task automatic do_move(input logic [3:0] loc);
    update_loc = loc;
    submit     = 1'b1;
    tick();
    submit     = 1'b0;
    tick();
  endtask

  task automatic game_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    tie_v[0] = '{4'd4, 9'h010, 9'h000, 1'b1, 4'd1, 1'b0, 2'b00};
    tie_v[1] = '{4'd0, 9'h010, 9'h001, 1'b0, 4'd2, 1'b0, 2'b00};
    tie_v[2] = '{4'd3, 9'h018, 9'h001, 1'b1, 4'd3, 1'b0, 2'b00};
    tie_v[3] = '{4'd5, 9'h018, 9'h021, 1'b0, 4'd4, 1'b0, 2'b00};
    tie_v[4] = '{4'd1, 9'h01A, 9'h021, 1'b1, 4'd5, 1'b0, 2'b00};
    tie_v[5] = '{4'd7, 9'h01A, 9'h0A1, 1'b0, 4'd6, 1'b0, 2'b00};
    tie_v[6] = '{4'd8, 9'h11A, 9'h0A1, 1'b1, 4'd7, 1'b0, 2'b00};
    tie_v[7] = '{4'd2, 9'h11A, 9'h0A5, 1'b0, 4'd8, 1'b0, 2'b00};
    tie_v[8] = '{4'd6, 9'h15A, 9'h0A5, 1'b0, 4'd9, 1'b1, 2'b11};
    ai_win_moves = '{4'd4, 4'd0, 4'd3, 4'd1, 4'd8, 4'd2};

    rst = 1'b1; reset = 1'b0; submit = 1'b0; update_loc = 4'd0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("rst_turn", 32'(turn0), 32'd0);
    chk("rst_bp", 32'(bp0), 32'h000);
    chk("rst_ba", 32'(ba0), 32'h000);
    chk("rst_cnt", 32'(cnt0), 32'd0);
    chk("rst_win", 32'(win0), 32'd0);
    chk("rst_over", 32'(over0), 32'd0);
    chk("rst_turn_ai_first", 32'(turn1), 32'd1);

    // Accept P4: mark one cycle after the edge, turn two.
    update_loc = 4'd4; submit = 1'b1;
    tick();
    chk("acc_bp", 32'(bp0), 32'h010);
    chk("acc_turn_early", 32'(turn0), 32'd0);
    submit = 1'b0;
    tick();
    chk("acc_turn", 32'(turn0), 32'd1);
    chk("acc_cnt", 32'(cnt0), 32'd1);

    // Occupied square and out-of-range square are rejected.
    for (int k = 0; k < 2; k++) begin
      update_loc = (k == 0) ? 4'd4 : 4'd9;
      submit = 1'b1;
      tick();
      chk("rej_err_hi", 32'(err0), 32'd1);
      chk("rej_bp", 32'(bp0), 32'h010);
      chk("rej_ba", 32'(ba0), 32'h000);
      submit = 1'b0;
      tick();
      chk("rej_err_lo", 32'(err0), 32'd0);
      chk("rej_turn", 32'(turn0), 32'd1);
      chk("rej_cnt", 32'(cnt0), 32'd1);
    end

    // Submit held high for four cycles: one accept only.
    update_loc = 4'd0; submit = 1'b1;
    repeat (4) tick();
    submit = 1'b0;
    tick();
    chk("hold_ba", 32'(ba0), 32'h001);
    chk("hold_cnt", 32'(cnt0), 32'd2);
    chk("hold_turn", 32'(turn0), 32'd0);
    chk("hold_err", 32'(err0), 32'd0);

    // Full game ending in a tie.
    game_reset();
    for (int i = 0; i < 9; i++) begin
      do_move(tie_v[i].loc);
      chk($sformatf("tie%0d_bp", i), 32'(bp0), 32'(tie_v[i].p));
      chk($sformatf("tie%0d_ba", i), 32'(ba0), 32'(tie_v[i].a));
      chk($sformatf("tie%0d_turn", i), 32'(turn0), 32'(tie_v[i].turn));
      chk($sformatf("tie%0d_cnt", i), 32'(cnt0), 32'(tie_v[i].cnt));
      chk($sformatf("tie%0d_over", i), 32'(over0), 32'(tie_v[i].over));
      chk($sformatf("tie%0d_win", i), 32'(win0), 32'(tie_v[i].win));
    end

    // AI wins on the top row; later submits are ignored.
    game_reset();
    chk("gr_cnt", 32'(cnt0), 32'd0);
    for (int i = 0; i < 6; i++) do_move(ai_win_moves[i]);
    chk("aiwin_ba", 32'(ba0), 32'h007);
    chk("aiwin_bp", 32'(bp0), 32'h118);
    chk("aiwin_win", 32'(win0), 32'b10);
    chk("aiwin_over", 32'(over0), 32'd1);
    chk("aiwin_cnt", 32'(cnt0), 32'd6);
    chk("aiwin_turn", 32'(turn0), 32'd1);
    do_move(4'd5);
    chk("over_ba", 32'(ba0), 32'h007);
    chk("over_bp", 32'(bp0), 32'h118);
    chk("over_win", 32'(win0), 32'b10);
    chk("over_err", 32'(err0), 32'd0);
    chk("over_cnt", 32'(cnt0), 32'd6);

    // Game reset, then hardware reset, landing on the S_CHECK cycle.
    for (int k = 0; k < 2; k++) begin
      game_reset();
      update_loc = 4'd4; submit = 1'b1;
      tick();
      chk("mid_bp_pre", 32'(bp0), 32'h010);
      submit = 1'b0;
      if (k == 0) reset = 1'b1; else rst = 1'b1;
      tick();
      reset = 1'b0; rst = 1'b0;
      chk("mid_bp", 32'(bp0), 32'h000);
      chk("mid_ba", 32'(ba0), 32'h000);
      chk("mid_turn", 32'(turn0), 32'd0);
      chk("mid_cnt", 32'(cnt0), 32'd0);
      chk("mid_ai_turn", 32'(turn1), 32'd1);
      chk("mid_ai_ba", 32'(ba1), 32'h000);
      tick();
      chk("mid_turn_stable", 32'(turn0), 32'd0);
      chk("mid_ai_turn_stable", 32'(turn1), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
